// File: rtl/eth_arb_pkg.sv
// Shared types and constants for the Ethernet TX frame arbiter.
package eth_arb_pkg;

  typedef enum logic [1:0] {IDLE, PASS, DRAIN} arb_state_e;

  localparam int unsigned FRAME_CNT_W = 32;
  localparam int unsigned ABORT_CNT_W = 16;
  localparam int unsigned ABORT_BIT   = 0;

endpackage

// File: rtl/rr_priority_select.sv
// Rotating-pointer priority encoder: first request at or after ptr, wrapping.
module rr_priority_select #(
  parameter int unsigned S_COUNT   = 4,
  parameter int unsigned SEL_WIDTH = $clog2(S_COUNT)
) (
  input  logic [S_COUNT-1:0]   req,
  input  logic [SEL_WIDTH-1:0] ptr,
  output logic                 gnt_valid,
  output logic [SEL_WIDTH-1:0] gnt_index
);

  logic [SEL_WIDTH-1:0] idx;

  // Scan from the farthest offset down so the nearest request wins last.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_index = '0;
    idx       = '0;
    for (int k = int'(S_COUNT) - 1; k >= 0; k--) begin
      idx = SEL_WIDTH'((int'(ptr) + k) % int'(S_COUNT));
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_index = idx;
      end
    end
  end

endmodule

// File: rtl/eth_tx_frame_arbiter.sv
// Frame-granular round-robin arbiter feeding the MAC TX stream, with a
// beat-count watchdog that truncates runaway frames and drains their tail.
module eth_tx_frame_arbiter
  import eth_arb_pkg::*;
#(
  parameter int unsigned S_COUNT    = 4,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned USER_WIDTH = 1,
  parameter int unsigned MAX_BEATS  = 1200,
  parameter int unsigned SEL_WIDTH  = $clog2(S_COUNT)
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [S_COUNT*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [S_COUNT-1:0]              s_axis_tvalid,
  output logic [S_COUNT-1:0]              s_axis_tready,
  input  logic [S_COUNT-1:0]              s_axis_tlast,
  input  logic [S_COUNT*USER_WIDTH-1:0]   s_axis_tuser,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic [USER_WIDTH-1:0]           m_axis_tuser,
  input  logic [S_COUNT-1:0]              src_enable,
  output logic                            grant_valid,
  output logic [SEL_WIDTH-1:0]            grant_index,
  output logic [FRAME_CNT_W-1:0]          frame_count,
  output logic [ABORT_CNT_W-1:0]          abort_count,
  output logic                            abort_pulse
);

  localparam int unsigned CNT_W = $clog2(MAX_BEATS + 2);

  arb_state_e           state;
  logic [SEL_WIDTH-1:0] rr_ptr;
  logic [SEL_WIDTH-1:0] sel_index;
  logic [SEL_WIDTH-1:0] next_ptr;
  logic                 sel_valid;
  logic [S_COUNT-1:0]   req;
  logic [CNT_W-1:0]     beat_cnt;
  logic                 out_free;
  logic                 src_hs;
  logic                 src_last;
  logic                 wd_hit;

  logic [DATA_WIDTH-1:0] src_data [S_COUNT];
  logic [USER_WIDTH-1:0] src_user [S_COUNT];

  for (genvar i = 0; i < S_COUNT; i++) begin : g_unpack
    assign src_data[i] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    assign src_user[i] = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
  end

  assign req = s_axis_tvalid & src_enable;

  rr_priority_select #(
    .S_COUNT   (S_COUNT),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_sel (
    .req       (req),
    .ptr       (rr_ptr),
    .gnt_valid (sel_valid),
    .gnt_index (sel_index)
  );

  assign out_free = !m_axis_tvalid || m_axis_tready;
  assign src_hs   = s_axis_tvalid[grant_index] && s_axis_tready[grant_index];
  assign src_last = s_axis_tlast[grant_index];
  assign wd_hit   = (MAX_BEATS != 0) && (beat_cnt == CNT_W'(MAX_BEATS - 1));
  assign next_ptr = (grant_index == SEL_WIDTH'(S_COUNT - 1)) ? '0
                                                             : grant_index + SEL_WIDTH'(1);

  // Only the granted source sees ready; DRAIN sinks its tail unconditionally.
  always_comb begin
    s_axis_tready = '0;
    if (state == PASS) begin
      s_axis_tready[grant_index] = out_free;
    end else if (state == DRAIN) begin
      s_axis_tready[grant_index] = 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      beat_cnt      <= '0;
      grant_valid   <= 1'b0;
      grant_index   <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= '0;
      frame_count   <= '0;
      abort_count   <= '0;
      abort_pulse   <= 1'b0;
    end else begin
      abort_pulse <= 1'b0;
      if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (sel_valid) begin
            grant_index <= sel_index;
            grant_valid <= 1'b1;
            state       <= PASS;
          end
        end
        PASS: begin
          if (src_hs) begin
            beat_cnt      <= beat_cnt + CNT_W'(1);
            m_axis_tdata  <= src_data[grant_index];
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= src_last;
            m_axis_tuser  <= src_user[grant_index];
            // tlast wins over the watchdog so an exactly MAX_BEATS frame is clean
            if (src_last) begin
              frame_count <= frame_count + FRAME_CNT_W'(1);
              rr_ptr      <= next_ptr;
              beat_cnt    <= '0;
              grant_valid <= 1'b0;
              state       <= IDLE;
            end else if (wd_hit) begin
              m_axis_tlast            <= 1'b1;
              m_axis_tuser[ABORT_BIT] <= 1'b1;
              abort_count             <= abort_count + ABORT_CNT_W'(1);
              abort_pulse             <= 1'b1;
              frame_count             <= frame_count + FRAME_CNT_W'(1);
              beat_cnt                <= '0;
              state                   <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (src_hs && src_last) begin
            rr_ptr      <= next_ptr;
            grant_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/eth_tx_frame_arbiter.md
Name: eth_tx_frame_arbiter

Overview:
- Frame-granular round-robin arbiter that shares the 1G MAC TX path (64-bit AXI-stream input, ahead of the TX FIFO and 64-to-8 width converter) between S_COUNT requesters, such as host queues, a PTP generator and a loopback path.
- The grant is held from the first beat of a frame until the tlast handshake, so frames never interleave.
- An optional length watchdog truncates runaway frames: it marks them bad and drains the rest of the frame from the source.

Parameters:
S_COUNT, 4, number of source ports (2..16)
DATA_WIDTH, 64, tdata width per port
USER_WIDTH, 1, tuser width; bit 0 is the bad-frame flag
MAX_BEATS, 1200, watchdog limit in beats per frame; 0 disables the watchdog
SEL_WIDTH, $clog2(S_COUNT), width of the grant index

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
s_axis_tdata  in  S_COUNT*DATA_WIDTH  source data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
s_axis_tvalid  in  S_COUNT  source valid
s_axis_tready  out  S_COUNT  source ready
s_axis_tlast  in  S_COUNT  source end of frame
s_axis_tuser  in  S_COUNT*USER_WIDTH  source user
m_axis_tdata  out  DATA_WIDTH  to MAC TX
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
m_axis_tlast  out  1  output end of frame
m_axis_tuser  out  USER_WIDTH  output user
src_enable  in  S_COUNT  per-source arbitration mask
grant_valid  out  1  a grant is active (PASS or DRAIN)
grant_index  out  SEL_WIDTH  granted source
frame_count  out  32  frames completed, wrapping
abort_count  out  16  watchdog truncations, wrapping
abort_pulse  out  1  one-cycle pulse when a frame is truncated

Behaviour:
- Reset (asynchronous, aresetn low):
  - all outputs are 0;
  - state = IDLE;
  - rr_ptr = 0;
  - beat_cnt = 0.
- The m_axis output is a single register stage. out_free = !m_axis_tvalid || m_axis_tready.
- IDLE:
  - req = s_axis_tvalid & src_enable.
  - If req is nonzero, choose the first set bit at or after rr_ptr, scanning upward with modulo-S_COUNT wrap.
  - Register it into grant_index and set grant_valid = 1; go to PASS.
  - s_axis_tready = 0 in IDLE.
- PASS:
  - s_axis_tready[grant_index] = out_free; all other ready bits are 0.
  - On each source handshake, load the beat into the m_axis register and increment beat_cnt.
  - On a handshake with tlast: frame_count += 1, rr_ptr = (grant_index + 1) mod S_COUNT, beat_cnt = 0, grant_valid = 0, go to IDLE.
  - On a handshake without tlast when MAX_BEATS != 0 and beat_cnt == MAX_BEATS-1:
    - output that beat with m_axis_tlast = 1 and m_axis_tuser[0] forced to 1;
    - abort_count += 1 and abort_pulse = 1 for one cycle;
    - frame_count also += 1 (a truncated frame still counts as completed);
    - go to DRAIN.
- DRAIN:
  - s_axis_tready[grant_index] = 1 unconditionally.
  - Beats are discarded and m_axis is not written.
  - On a tlast handshake: update rr_ptr, set grant_valid = 0, go to IDLE.
- Latency:
  - In IDLE, a source's tvalid rising edge produces its first beat on m_axis 2 cycles later.
  - Throughput in PASS is 1 beat per cycle while m_axis_tready = 1.
  - There is 1 idle cycle between consecutive frames (the IDLE re-arbitration).
- tuser passes through unchanged on every beat except the forced abort beat.
- src_enable deasserted mid-frame does not revoke an active grant; it only masks the next arbitration.
- A granted source deasserting tvalid mid-frame stalls the output with no timeout. The watchdog counts beats, not cycles.
- A frame of exactly MAX_BEATS beats, with tlast on beat MAX_BEATS, completes normally: the tlast check takes priority over the watchdog.
- A single-beat frame (tlast on beat 1) is valid.
- Backpressure while m_axis holds a beat never drops or duplicates data. The m_axis register holds until its handshake.
- A reset mid-frame truncates the output silently. Sources are required to share the reset domain.

Decomposition:
- Package eth_arb_pkg contains:
  - the state enum {IDLE, PASS, DRAIN};
  - the counter widths (32 and 16);
  - the abort flag bit index (0).
- One sub-module: rr_priority_select.
  - Combinational rotating-pointer priority encoder.
  - Inputs: req[S_COUNT], ptr[SEL_WIDTH].
  - Outputs: gnt_valid, gnt_index.

Test Plan:
- Sources 0 and 2 both present 3-beat frames, rr_ptr = 0 → output carries src0 frame, then src2 frame; frame_count = 2; grant_index sequence 0, 2.
- All 4 sources continuously request 1-beat frames → grants rotate 0, 1, 2, 3, 0; each source receives exactly 1 of every 4 grants.
- MAX_BEATS = 4, source 1 sends a 6-beat frame → output has 4 beats, beat 4 with tlast = 1 and tuser[0] = 1; source beats 5–6 are accepted and dropped; abort_count = 1; abort_pulse is high for 1 cycle.
- m_axis_tready toggles 1, 0, 0, 1 during an 8-beat frame → output data matches source order exactly; no loss or duplication.
- src_enable = 4'b1011 while source 2 is requesting → source 2 is never granted; after src_enable = 4'b1111 it is granted in the next IDLE.
- aresetn pulsed low mid-frame → all outputs are 0 immediately; after release, arbitration restarts from rr_ptr = 0.
